// File: rtl/can_err_pkg.sv
// Shared types and constants for the CAN error-frame handler and its REC counter.
package can_err_pkg;

   localparam int FLAG_LEN      = 6;
   localparam int DELIM_LEN     = 8;
   localparam int REC_W         = 8;
   localparam int PASSIVE_LIMIT = 128;
   localparam int REC_RELOAD    = 119;

   // Consecutive dominant bits after the flag that earn another +8.
   localparam int DOM_LIMIT     = 8;

   localparam int BIT_W   = $clog2(FLAG_LEN);
   localparam int DELIM_W = $clog2(DELIM_LEN);
   localparam int DOM_W   = $clog2(DOM_LIMIT);

   localparam logic [BIT_W-1:0]   FLAG_LAST  = BIT_W'(FLAG_LEN - 1);
   localparam logic [DELIM_W-1:0] DELIM_LAST = DELIM_W'(DELIM_LEN - 1);
   localparam logic [DOM_W-1:0]   DOM_LAST   = DOM_W'(DOM_LIMIT - 1);

   localparam logic [REC_W-1:0] REC_PASSIVE  = REC_W'(PASSIVE_LIMIT);
   localparam logic [REC_W-1:0] REC_RELOAD_V = REC_W'(REC_RELOAD);

   typedef enum logic [1:0] {
      IDLE,
      FLAG,
      WAIT_REC,
      DELIM
   } state_e;

   typedef enum logic [1:0] {
      INC_NONE,
      INC1,
      INC8
   } rec_inc_e;

endpackage

// File: rtl/can_error_frame_if.sv
// Bus-side signals between error detection / frame decoder and the error-frame handler.
interface can_error_frame_if;
   import can_err_pkg::*;

   logic             ERROR;
   logic             RX;
   logic             Frame_OK;
   logic             TX;
   logic             Error_Frame;
   logic             Err_Passive;
   logic [REC_W-1:0] REC;
   logic             Resync;

   modport master (
      output ERROR, RX, Frame_OK,
      input  TX, Error_Frame, Err_Passive, REC, Resync
   );

   modport slave (
      input  ERROR, RX, Frame_OK,
      output TX, Error_Frame, Err_Passive, REC, Resync
   );

endinterface

// File: rtl/can_rec_counter.sv
// Receive error counter: saturating +1/+8, decrement or reload on a good frame,
// and the error-passive indication derived from the count.
module can_rec_counter
   import can_err_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             inc1,
   input  logic             inc8,
   input  logic             frameOk,
   output logic [REC_W-1:0] rec,
   output logic             errPassive
);

   localparam logic [REC_W:0] REC_MAX = {1'b0, {REC_W{1'b1}}};

   logic [REC_W:0] sum;

   // Widened sum so an overflow past the top of the counter can be seen and clamped.
   always_comb begin
      sum = {1'b0, rec} + (inc8 ? (REC_W+1)'(8) : (REC_W+1)'(1));
   end

   // Increments take priority; a good frame decrements, reloads when passive, or holds at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         rec <= '0;
      end else if (inc1 || inc8) begin
         rec <= (sum > REC_MAX) ? {REC_W{1'b1}} : sum[REC_W-1:0];
      end else if (frameOk) begin
         if (rec >= REC_PASSIVE) begin
            rec <= REC_RELOAD_V;
         end else if (rec != '0) begin
            rec <= rec - 1'b1;
         end
      end
   end

   assign errPassive = (rec >= REC_PASSIVE);

endmodule

// File: rtl/can_error_frame.sv
// CAN error-frame handler: drives the error flag, waits out flag superposition
// and the delimiter, updates REC and requests decoder resync when done.
module can_error_frame
   import can_err_pkg::*;
(
   input  logic              SP,
   input  logic              reset,
   can_error_frame_if.slave  bus
);

   state_e               state;
   logic                 flagActive;
   logic [BIT_W-1:0]     bitCnt;
   logic [DELIM_W-1:0]   delimCnt;
   logic [DOM_W-1:0]     domCnt;
   logic                 txReg;
   logic                 errorFrameReg;
   logic                 resyncReg;

   rec_inc_e             recInc;
   logic                 frameOkStb;
   logic                 errPassive;
   logic [REC_W-1:0]     recVal;

   // REC update requests for the current bit; the last flag edge doubles as the
   // first bit after the flag, where domCnt is still zero so only the active-flag +8 applies.
   always_comb begin
      recInc     = INC_NONE;
      frameOkStb = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ERROR) begin
               recInc = INC1;
            end else if (bus.Frame_OK) begin
               frameOkStb = 1'b1;
            end
         end
         FLAG: begin
            if (bitCnt == FLAG_LAST && !bus.RX && flagActive) begin
               recInc = INC8;
            end
         end
         WAIT_REC: begin
            if (!bus.RX && domCnt == DOM_LAST) begin
               recInc = INC8;
            end
         end
         DELIM: begin
            if (!bus.RX) begin
               recInc = INC1;
            end
         end
         default: ;
      endcase
   end

   // Error-frame sequencer with registered TX, Error_Frame and Resync.
   always_ff @(posedge SP) begin
      if (reset) begin
         state         <= IDLE;
         txReg         <= 1'b1;
         errorFrameReg <= 1'b0;
         resyncReg     <= 1'b0;
         flagActive    <= 1'b0;
         bitCnt        <= '0;
         delimCnt      <= '0;
         domCnt        <= '0;
      end else begin
         resyncReg <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.ERROR) begin
                  state         <= FLAG;
                  flagActive    <= ~errPassive;
                  txReg         <= errPassive;
                  errorFrameReg <= 1'b1;
                  bitCnt        <= '0;
                  delimCnt      <= '0;
                  domCnt        <= '0;
               end
            end
            FLAG: begin
               if (bitCnt != FLAG_LAST) begin
                  bitCnt <= bitCnt + 1'b1;
               end else begin
                  txReg <= 1'b1;
                  if (bus.RX) begin
                     state    <= DELIM;
                     delimCnt <= DELIM_W'(1);
                  end else begin
                     state  <= WAIT_REC;
                     domCnt <= DOM_W'(1);
                  end
               end
            end
            WAIT_REC: begin
               if (bus.RX) begin
                  state    <= DELIM;
                  delimCnt <= DELIM_W'(1);
               end else if (domCnt == DOM_LAST) begin
                  domCnt <= '0;
               end else begin
                  domCnt <= domCnt + 1'b1;
               end
            end
            DELIM: begin
               if (bus.RX) begin
                  if (delimCnt == DELIM_LAST) begin
                     state         <= IDLE;
                     resyncReg     <= 1'b1;
                     errorFrameReg <= 1'b0;
                     delimCnt      <= '0;
                  end else begin
                     delimCnt <= delimCnt + 1'b1;
                  end
               end else begin
                  state      <= FLAG;
                  flagActive <= ~errPassive;
                  txReg      <= errPassive;
                  bitCnt     <= '0;
                  delimCnt   <= '0;
                  domCnt     <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   can_rec_counter u_rec (
      .clk        (SP),
      .reset      (reset),
      .inc1       (recInc == INC1),
      .inc8       (recInc == INC8),
      .frameOk    (frameOkStb),
      .rec        (recVal),
      .errPassive (errPassive)
   );

   assign bus.TX          = txReg;
   assign bus.Error_Frame = errorFrameReg;
   assign bus.Resync      = resyncReg;
   assign bus.REC         = recVal;
   assign bus.Err_Passive = errPassive;

endmodule

// File: tb/tb_can_error_frame.sv
// Directed bench for can_error_frame: walks through reset, active/passive error
// frames, superposition, delimiter form errors, Frame_OK handling and saturation.
module tb_can_error_frame;
   import can_err_pkg::*;

   logic SP = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   can_error_frame_if bus ();

   can_error_frame dut (
      .SP    (SP),
      .reset (reset),
      .bus   (bus)
   );

   // Bit sample-point strobe.
   always #5 SP = ~SP;

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic checkRec(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic tx, input logic ef,
                              input logic [REC_W-1:0] rec, input logic ep, input logic rs);
      checkBit({tag, "_tx"}, bus.TX, tx);
      checkBit({tag, "_ef"}, bus.Error_Frame, ef);
      checkRec({tag, "_rec"}, bus.REC, rec);
      checkBit({tag, "_ep"}, bus.Err_Passive, ep);
      checkBit({tag, "_rs"}, bus.Resync, rs);
   endtask

   // One bit time: drive inputs, let one SP edge pass, sample 1 time unit later.
   task automatic applyStimulus(input logic err, input logic rx, input logic fok);
      bus.ERROR    = err;
      bus.RX       = rx;
      bus.Frame_OK = fok;
      @(posedge SP);
      #1;
      bus.ERROR    = 1'b0;
      bus.Frame_OK = 1'b0;
   endtask

   task automatic bits(input int n, input logic rx);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, rx, 1'b0);
   endtask

   task automatic flagBits(input int n, input logic expTx, input string tag);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         checkBit({tag, "_tx"}, bus.TX, expTx);
         checkBit({tag, "_ef"}, bus.Error_Frame, 1'b1);
      end
   endtask

   initial begin
      $display("[TB] can_error_frame directed test start");
      bus.ERROR = 1'b0; bus.RX = 1'b1; bus.Frame_OK = 1'b0;
      reset = 1'b1;
      bits(2, 1'b1);
      reset = 1'b0;
      checkOutput("reset", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

      // Active error frame, bus recessive throughout.
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("act_e1", 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
      flagBits(5, 1'b0, "act_flag");
      for (int i = 7; i <= 13; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         checkBit("act_delim_tx", bus.TX, 1'b1);
         checkBit("act_delim_rs", bus.Resync, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("act_e14", 1'b1, 1'b0, 8'd1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkBit("act_e15_rs", bus.Resync, 1'b0);

      // Frame_OK decrements to zero and holds there.
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkRec("fok_1to0", bus.REC, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkRec("fok_0to0", bus.REC, 8'd0);

      // Reset held for two edges in the middle of a flag.
      applyStimulus(1'b1, 1'b1, 1'b0);
      bits(2, 1'b1);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkBit("rst_mid_e1_tx", bus.TX, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      reset = 1'b0;
      checkOutput("rst_mid", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("rst_idle", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

      // Superposition: one dominant bit after the flag.
      applyStimulus(1'b1, 1'b1, 1'b0);
      bits(5, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("sup1_e7", 1'b1, 1'b1, 8'd9, 1'b0, 1'b0);
      bits(7, 1'b1);
      checkBit("sup1_e14_rs", bus.Resync, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("sup1_e15", 1'b1, 1'b0, 8'd9, 1'b0, 1'b1);

      // Superposition: eight dominant bits after the flag (REC 9 -> 26).
      applyStimulus(1'b1, 1'b1, 1'b0);
      bits(5, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkRec("sup8_e7", bus.REC, 8'd18);
      bits(6, 1'b0);
      checkRec("sup8_e13", bus.REC, 8'd18);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkRec("sup8_e14", bus.REC, 8'd26);
      bits(7, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("sup8_end", 1'b1, 1'b0, 8'd26, 1'b0, 1'b1);

      // Form error on delimiter bit 4 restarts an active flag.
      applyStimulus(1'b1, 1'b1, 1'b0);
      bits(5, 1'b1);
      bits(3, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("form_e10", 1'b0, 1'b1, 8'd28, 1'b0, 1'b0);
      flagBits(5, 1'b0, "form_flag");
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkBit("form_e16_tx", bus.TX, 1'b1);
      bits(6, 1'b1);
      checkBit("form_e22_rs", bus.Resync, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("form_end", 1'b1, 1'b0, 8'd28, 1'b0, 1'b1);

      // Frame_OK down to 5, then ERROR and Frame_OK together.
      for (int i = 0; i < 23; i++) applyStimulus(1'b0, 1'b1, 1'b1);
      checkRec("fok_to5", bus.REC, 8'd5);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("err_fok", 1'b0, 1'b1, 8'd6, 1'b0, 1'b0);
      bits(12, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkBit("err_fok_rs", bus.Resync, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkRec("fok_6to5", bus.REC, 8'd5);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkRec("fok_5to4", bus.REC, 8'd4);

      // Build REC up to 127: 1 + 8 + 14*8 = 121, then six delimiter form errors.
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      reset = 1'b0;
      checkRec("pre_rst", bus.REC, 8'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      bits(5, 1'b1);
      bits(112, 1'b0);
      checkRec("pre_121", bus.REC, 8'd121);
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         bits(5, 1'b1);
         applyStimulus(1'b0, 1'b1, 1'b0);
      end
      bits(6, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("pre_127", 1'b1, 1'b0, 8'd127, 1'b0, 1'b1);

      // Crossing into error-passive: this flag is still active.
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("pas_enter", 1'b0, 1'b1, 8'd128, 1'b1, 1'b0);
      bits(12, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("pas_enter_end", 1'b1, 1'b0, 8'd128, 1'b1, 1'b1);

      // Passive flag: recessive throughout, no +8 on a dominant first bit.
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("pas_e1", 1'b1, 1'b1, 8'd129, 1'b1, 1'b0);
      flagBits(5, 1'b1, "pas_flag");
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkRec("pas_first_dom", bus.REC, 8'd129);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pas_form", 1'b1, 1'b1, 8'd130, 1'b1, 1'b0);
      bits(5, 1'b1);
      bits(7, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("pas_end", 1'b1, 1'b0, 8'd130, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("fok_reload", 1'b1, 1'b0, 8'd119, 1'b0, 1'b0);

      // Saturation: 120 + 8 + 15*8 = 248, two form errors to 250, then repeated +8.
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkBit("sat_e1_tx", bus.TX, 1'b0);
      bits(5, 1'b1);
      bits(120, 1'b0);
      checkRec("sat_248", bus.REC, 8'd248);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("sat_form1", 1'b1, 1'b1, 8'd249, 1'b1, 1'b0);
      bits(5, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkRec("sat_form2", bus.REC, 8'd250);
      bits(5, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkRec("sat_first", bus.REC, 8'd250);
      bits(7, 1'b0);
      checkRec("sat_255a", bus.REC, 8'd255);
      bits(8, 1'b0);
      checkRec("sat_255b", bus.REC, 8'd255);
      bits(7, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("sat_end", 1'b1, 1'b0, 8'd255, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkRec("sat_reload", bus.REC, 8'd119);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
